dc_req_scheduler: RTL and testbench
===================================

Name: dc_req_scheduler

Overview:
- Owns the single D-cache request port and shares it between three requesters: pipeline loads (MEM stage), value-prediction replay loads (verification of predicted load values), and a small store buffer.
- Pipeline stores are posted into the store buffer and acknowledged immediately. Loads and store drains are serialised, one outstanding cache transaction at a time.
- Sits between EX/MEM and d_cache, alongside the hazard controller.

Parameters:
ADDR_W, 26, word-address width
DATA_W, 32, data width
SB_DEPTH, 4, store buffer entries (power of 2, >=2)
MAX_REP_STREAK, 3, consecutive replay grants before a waiting pipeline load is forced one grant

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
pipe_req_valid  in  1  pipeline request valid
pipe_req_write  in  1  1=store, 0=load
pipe_req_addr  in  ADDR_W  pipeline address
pipe_req_data  in  DATA_W  store data
pipe_req_ready  out  1  pipeline request accepted this cycle when valid&ready
pipe_rsp_valid  out  1  load data valid (one-cycle pulse)
pipe_rsp_data  out  DATA_W  load data
rep_req_valid  in  1  replay load request
rep_req_addr  in  ADDR_W  replay address
rep_req_ready  out  1  replay accepted
rep_rsp_valid  out  1  replay data valid (pulse)
rep_rsp_data  out  DATA_W  replay data
flush  in  1  squash in-flight or pending pipeline load
dc_req_valid  out  1  cache request valid
dc_req_write  out  1  cache request is write
dc_req_addr  out  ADDR_W  cache address
dc_req_data  out  DATA_W  cache write data
dc_rsp_valid  in  1  cache completion (read data or write ack)
dc_rsp_data  in  DATA_W  cache read data
sb_count  out  $clog2(SB_DEPTH)+1  occupied store buffer entries
busy  out  1  transaction in flight or sb_count!=0

Behaviour:
- Reset values: all outputs 0; FSM IDLE; store buffer empty; streak counter 0. Reset mid-transaction drops dc_req_valid asynchronously and discards buffered stores.
- FSM has two states, IDLE and WAIT. A register owner records the current requester: PIPE_LD, REP_LD or SB_ST.
- IDLE grant priority, evaluated combinationally, first match wins:
  1. Store buffer full → drain the head entry.
  2. rep_req_valid and streak<MAX_REP_STREAK → replay load.
  3. Pipeline load valid and load-eligible → pipeline load.
  4. rep_req_valid (streak saturated, no eligible pipe load) → replay load.
  5. sb_count!=0 → drain the head entry.
- Any grant moves IDLE→WAIT next cycle. dc_req_* are registered at grant and held stable throughout WAIT.
- Streak counter: increments on each replay grant. Clears on a pipeline-load grant, or when no replay request is pending in IDLE.
- WAIT→IDLE on dc_rsp_valid. At least one IDLE cycle separates transactions.
- Read responses: pipe_rsp_*/rep_rsp_* are registered, valid the cycle after dc_rsp_valid (owner selects which).
- SB_ST completion pops the head entry on dc_rsp_valid.
- Pipeline stores: pipe_req_ready = ~full (registered occupancy), independent of FSM state. Enqueue on valid&ready&write. Enqueue and pop in the same cycle are allowed when not full.
- Pipeline loads: pipe_req_ready = grant to PIPE_LD (or a forward hit, see Optional Feature). Ready does not depend on pipe_req_valid.
- rep_req_ready = grant to REP_LD.
- flush: a PIPE_LD in WAIT completes on the cache, but its pipe_rsp_valid is suppressed. A pending, unaccepted load is the requester's responsibility. Stores already buffered are never flushed.
- Full buffer with a store arriving: ready=0 until a pop is registered.
- Simultaneous store enqueue and load to the same address: the store is enqueued first; the load sees it next cycle.

Optional Feature:
- Macro: DC_SCHED_STORE_FWD_EN.
- Defined:
  - A pipeline load is load-eligible unconditionally.
  - If its address matches any store-buffer entry, it is accepted in IDLE or WAIT without using the cache port.
  - pipe_rsp_data = youngest matching entry's data, pipe_rsp_valid the next cycle.
- Undefined:
  - A pipeline load is load-eligible only when sb_count==0.
  - Otherwise the buffer drains first (rule 5 applies ahead of rule 3).

Decomposition:
- Package dc_sched_pkg holds:
  - owner_e {PIPE_LD, REP_LD, SB_ST}
  - state_e {IDLE, WAIT}
  - sb_entry_t {addr, data}
- Sub-module dc_store_buffer:
  - circular FIFO with push, pop, head, count and full
  - an address-match lookup returning a youngest-hit flag and data (forward path)

Test Plan:
- Store addr 0x10 data 0xAA, then load 0x10 → with FWD_EN: pipe_rsp_data=0xAA one cycle after accept, no dc_req. Without: dc write 0x10 issued first, then dc read 0x10.
- Four stores (SB_DEPTH=4), with dc_rsp_valid held off → pipe_req_ready=0 on the 5th store. A drain is issued first. After the first dc_rsp_valid, ready returns 1 the next cycle.
- rep_req_valid and a pipeline load held continuously, MAX_REP_STREAK=3 → grant sequence REP,REP,REP,PIPE,REP.
- Pipeline load 0x20 in WAIT, flush pulsed, then dc_rsp_valid with 0x55 → pipe_rsp_valid stays 0, FSM returns to IDLE.
- rst asserted in WAIT with sb_count=2 → dc_req_valid=0 immediately, sb_count=0, busy=0.
- Replay load 0x30 with the cache returning 0x1234 after 5 cycles → rep_rsp_valid pulses once with 0x1234. dc_req_addr stays 0x30 throughout WAIT.

Source files
------------

// File: rtl/dc_sched_pkg.sv
// Shared types for the D-cache request scheduler: requester ids, FSM states and store-buffer entries.
// Entry field widths are fixed here; the top-level ADDR_W/DATA_W must stay equal to them.
package dc_sched_pkg;

  localparam int SB_ADDR_W = 26;
  localparam int SB_DATA_W = 32;

  typedef enum logic [1:0] {
    PIPE_LD = 2'd0,
    REP_LD  = 2'd1,
    SB_ST   = 2'd2
  } owner_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/dc_store_buffer.sv
// Circular store FIFO feeding cache drains; push/pop same cycle allowed, full when count==DEPTH.
// With DC_SCHED_STORE_FWD_EN a combinational lookup returns the youngest entry matching lk_addr.
module dc_store_buffer
  import dc_sched_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  sb_entry_t            push_entry,
  input  logic                 pop,
  output sb_entry_t            head,
  output logic [CW-1:0]        count,
  output logic                 full
`ifdef DC_SCHED_STORE_FWD_EN
  ,
  input  logic [SB_ADDR_W-1:0] lk_addr,
  output logic                 lk_hit,
  output logic [SB_DATA_W-1:0] lk_data
`endif
);

  sb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];
  assign full = (count == CW'(DEPTH));

`ifdef DC_SCHED_STORE_FWD_EN
  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last hit left standing is the youngest store.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    idx     = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (mem[idx].addr == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = mem[idx].data;
      end
    end
  end
`endif

endmodule

// File: rtl/dc_req_scheduler.sv
// Shares the single D-cache port between pipeline loads, replay loads and store-buffer drains, one transaction at a time.
// Grant in IDLE -> registered request held through WAIT; responses one cycle after dc_rsp_valid. Option: DC_SCHED_STORE_FWD_EN.
module dc_req_scheduler
  import dc_sched_pkg::*;
#(
  parameter int ADDR_W         = 26,
  parameter int DATA_W         = 32,
  parameter int SB_DEPTH       = 4,
  parameter int MAX_REP_STREAK = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pipe_req_valid,
  input  logic                      pipe_req_write,
  input  logic [ADDR_W-1:0]         pipe_req_addr,
  input  logic [DATA_W-1:0]         pipe_req_data,
  output logic                      pipe_req_ready,
  output logic                      pipe_rsp_valid,
  output logic [DATA_W-1:0]         pipe_rsp_data,
  input  logic                      rep_req_valid,
  input  logic [ADDR_W-1:0]         rep_req_addr,
  output logic                      rep_req_ready,
  output logic                      rep_rsp_valid,
  output logic [DATA_W-1:0]         rep_rsp_data,
  input  logic                      flush,
  output logic                      dc_req_valid,
  output logic                      dc_req_write,
  output logic [ADDR_W-1:0]         dc_req_addr,
  output logic [DATA_W-1:0]         dc_req_data,
  input  logic                      dc_rsp_valid,
  input  logic [DATA_W-1:0]         dc_rsp_data,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      busy
);

  localparam int STW = $clog2(MAX_REP_STREAK + 1);

  state_e          state;
  owner_e          owner;
  logic [STW-1:0]  streak;
  logic            squashed;

  sb_entry_t       sb_wr;
  sb_entry_t       sb_head;
  logic            sb_full;
  logic            sb_push;
  logic            sb_pop;

  logic            pipe_ld;
  logic            pipe_ld_cache;
  logic            fwd_acc;
  logic            grant_vld;
  owner_e          grant_own;

  assign pipe_ld  = pipe_req_valid & ~pipe_req_write;
  assign sb_push  = pipe_req_valid & pipe_req_write & pipe_req_ready;
  assign sb_pop   = (state == WAIT) && (owner == SB_ST) && dc_rsp_valid;
  assign sb_wr.addr = pipe_req_addr;
  assign sb_wr.data = pipe_req_data;

`ifdef DC_SCHED_STORE_FWD_EN
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // A forwarded load must not land in the same cycle as an in-flight pipeline load's response.
  assign fwd_acc       = pipe_ld & fwd_hit & ~((state == WAIT) && (owner == PIPE_LD));
  assign pipe_ld_cache = pipe_ld & ~fwd_hit;
`else
  assign fwd_acc       = 1'b0;
  assign pipe_ld_cache = pipe_ld & (sb_count == '0);
`endif

  dc_store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (sb_push),
    .push_entry (sb_wr),
    .pop        (sb_pop),
    .head       (sb_head),
    .count      (sb_count),
    .full       (sb_full)
`ifdef DC_SCHED_STORE_FWD_EN
    ,
    .lk_addr    (pipe_req_addr),
    .lk_hit     (fwd_hit),
    .lk_data    (fwd_data)
`endif
  );

  always_comb begin
    grant_vld = 1'b0;
    grant_own = PIPE_LD;
    if (state == IDLE) begin
      if (sb_full) begin
        grant_vld = 1'b1;
        grant_own = SB_ST;
      end else if (rep_req_valid && (streak < STW'(MAX_REP_STREAK))) begin
        grant_vld = 1'b1;
        grant_own = REP_LD;
      end else if (pipe_ld_cache) begin
        grant_vld = 1'b1;
        grant_own = PIPE_LD;
      end else if (rep_req_valid) begin
        grant_vld = 1'b1;
        grant_own = REP_LD;
      end else if (sb_count != '0) begin
        grant_vld = 1'b1;
        grant_own = SB_ST;
      end
    end
  end

  assign pipe_req_ready = ~rst & (pipe_req_write ? ~sb_full
                                                 : ((grant_vld && (grant_own == PIPE_LD)) || fwd_acc));
  assign rep_req_ready  = ~rst & grant_vld & (grant_own == REP_LD);
  assign busy           = (state == WAIT) || (sb_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      owner          <= PIPE_LD;
      streak         <= '0;
      squashed       <= 1'b0;
      dc_req_valid   <= 1'b0;
      dc_req_write   <= 1'b0;
      dc_req_addr    <= '0;
      dc_req_data    <= '0;
      pipe_rsp_valid <= 1'b0;
      pipe_rsp_data  <= '0;
      rep_rsp_valid  <= 1'b0;
      rep_rsp_data   <= '0;
    end else begin
      pipe_rsp_valid <= 1'b0;
      rep_rsp_valid  <= 1'b0;
      if (state == IDLE) begin
        if (grant_vld) begin
          state        <= WAIT;
          owner        <= grant_own;
          squashed     <= flush;
          dc_req_valid <= 1'b1;
          dc_req_write <= (grant_own == SB_ST);
          dc_req_addr  <= (grant_own == SB_ST)  ? sb_head.addr :
                          (grant_own == REP_LD) ? rep_req_addr : pipe_req_addr;
          dc_req_data  <= (grant_own == SB_ST) ? sb_head.data : '0;
        end
        if (grant_vld && (grant_own == REP_LD)) begin
          if (streak != STW'(MAX_REP_STREAK)) streak <= streak + 1'b1;
        end else if ((grant_vld && (grant_own == PIPE_LD)) || !rep_req_valid) begin
          streak <= '0;
        end
      end else begin
        if (flush) squashed <= 1'b1;
        if (dc_rsp_valid) begin
          state        <= IDLE;
          dc_req_valid <= 1'b0;
          if (owner == PIPE_LD) begin
            pipe_rsp_valid <= ~(squashed | flush);
            pipe_rsp_data  <= dc_rsp_data;
          end
          if (owner == REP_LD) begin
            rep_rsp_valid <= 1'b1;
            rep_rsp_data  <= dc_rsp_data;
          end
        end
      end
`ifdef DC_SCHED_STORE_FWD_EN
      if (fwd_acc) begin
        pipe_rsp_valid <= ~flush;
        pipe_rsp_data  <= fwd_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dc_req_scheduler.sv
// Directed table of per-cycle stimulus/expectations plus hand-written replay-latency and mid-cycle reset sequences.
module tb_dc_req_scheduler;

  logic        clk;
  logic        rst;
  logic        pipe_req_valid, pipe_req_write, pipe_req_ready;
  logic [25:0] pipe_req_addr;
  logic [31:0] pipe_req_data;
  logic        pipe_rsp_valid;
  logic [31:0] pipe_rsp_data;
  logic        rep_req_valid, rep_req_ready, rep_rsp_valid;
  logic [25:0] rep_req_addr;
  logic [31:0] rep_rsp_data;
  logic        flush;
  logic        dc_req_valid, dc_req_write;
  logic [25:0] dc_req_addr;
  logic [31:0] dc_req_data;
  logic        dc_rsp_valid;
  logic [31:0] dc_rsp_data;
  logic [2:0]  sb_count;
  logic        busy;

  dc_req_scheduler dut (
    .clk(clk), .rst(rst),
    .pipe_req_valid(pipe_req_valid), .pipe_req_write(pipe_req_write),
    .pipe_req_addr(pipe_req_addr), .pipe_req_data(pipe_req_data),
    .pipe_req_ready(pipe_req_ready), .pipe_rsp_valid(pipe_rsp_valid),
    .pipe_rsp_data(pipe_rsp_data), .rep_req_valid(rep_req_valid),
    .rep_req_addr(rep_req_addr), .rep_req_ready(rep_req_ready),
    .rep_rsp_valid(rep_rsp_valid), .rep_rsp_data(rep_rsp_data),
    .flush(flush), .dc_req_valid(dc_req_valid), .dc_req_write(dc_req_write),
    .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
    .sb_count(sb_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, pv, pw;
    logic [25:0] pa;
    logic [31:0] pd;
    logic        rv;
    logic [25:0] ra;
    logic        fl, rsv;
    logic [31:0] rsd;
    logic        e_pr, e_rr, e_dv, e_dw;
    logic [25:0] e_da;
    logic [31:0] e_dd;
    logic        e_prv, e_rrv;
    logic [31:0] e_rd;
    logic [2:0]  e_cnt;
    logic        e_busy;
  } vec_t;

  vec_t tv[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic v(input logic [31:0] r, pv, pw, pa, pd, rv, ra, fl, rsv, rsd,
                   input logic [31:0] pr, rr, dv, dw, da, dd, prv, rrv, rd, cnt, bz);
    vec_t t;
    t.rst = r[0]; t.pv = pv[0]; t.pw = pw[0]; t.pa = pa[25:0]; t.pd = pd;
    t.rv = rv[0]; t.ra = ra[25:0]; t.fl = fl[0]; t.rsv = rsv[0]; t.rsd = rsd;
    t.e_pr = pr[0]; t.e_rr = rr[0]; t.e_dv = dv[0]; t.e_dw = dw[0];
    t.e_da = da[25:0]; t.e_dd = dd; t.e_prv = prv[0]; t.e_rrv = rrv[0];
    t.e_rd = rd; t.e_cnt = cnt[2:0]; t.e_busy = bz[0];
    tv.push_back(t);
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", nm, row, act, exp);
    end
  endtask

  task automatic drive_idle();
    pipe_req_valid = 0; pipe_req_write = 0; pipe_req_addr = '0; pipe_req_data = '0;
    rep_req_valid = 0; rep_req_addr = '0; flush = 0; dc_rsp_valid = 0; dc_rsp_data = '0;
  endtask

  int pulses;

  initial begin
    rst = 1'b1;
    drive_idle();

    //  rst pv pw pa    pd     rv ra    fl rsv rsd      | pr rr dv dw da    dd     prv rrv rd       cnt bz
`ifdef DC_SCHED_STORE_FWD_EN
    // store 0x10 then load 0x10: forwarded from the buffer, cache sees only the drain
    v(1, 0,0,0,    0,     0,0,    0,0,  0,         0,0,0,0,0,    0,     0,0,0,       0,0);
    v(0, 1,1,'h10, 'hAA,  0,0,    0,0,  0,         1,0,0,0,0,    0,     0,0,0,       0,0);
    v(0, 1,0,'h10, 0,     0,0,    0,0,  0,         1,0,0,0,0,    0,     0,0,0,       1,1);
    v(0, 0,0,0,    0,     0,0,    0,0,  0,         0,0,1,1,'h10, 'hAA,  1,0,'hAA,    1,1);
    v(0, 0,0,0,    0,     0,0,    0,1,  0,         0,0,1,1,'h10, 'hAA,  0,0,0,       1,1);
    v(0, 0,0,0,    0,     0,0,    0,0,  0,         0,0,0,0,0,    0,     0,0,0,       0,0);
`else
    // store 0x10 then load 0x10: buffer drains (write) before the load reads the cache
    v(1, 0,0,0,    0,     0,0,    0,0,  0,         0,0,0,0,0,    0,     0,0,0,       0,0);
    v(0, 0,0,0,    0,     0,0,    0,0,  0,         0,0,0,0,0,    0,     0,0,0,       0,0);
    v(0, 1,1,'h10, 'hAA,  0,0,    0,0,  0,         1,0,0,0,0,    0,     0,0,0,       0,0);
    v(0, 1,0,'h10, 0,     0,0,    0,0,  0,         0,0,0,0,0,    0,     0,0,0,       1,1);
    v(0, 1,0,'h10, 0,     0,0,    0,0,  0,         0,0,1,1,'h10, 'hAA,  0,0,0,       1,1);
    v(0, 1,0,'h10, 0,     0,0,    0,1,  0,         0,0,1,1,'h10, 'hAA,  0,0,0,       1,1);
    v(0, 1,0,'h10, 0,     0,0,    0,0,  0,         1,0,0,0,0,    0,     0,0,0,       0,0);
    v(0, 0,0,0,    0,     0,0,    0,0,  0,         0,0,1,0,'h10, 0,     0,0,0,       0,1);
    v(0, 0,0,0,    0,     0,0,    0,1,  'h77,      0,0,1,0,'h10, 0,     0,0,0,       0,1);
    v(0, 0,0,0,    0,     0,0,    0,0,  0,         0,0,0,0,0,    0,     1,0,'h77,    0,0);
    v(0, 0,0,0,    0,     0,0,    0,0,  0,         0,0,0,0,0,    0,     0,0,0,       0,0);
`endif
    // fill to SB_DEPTH with the drain stalled: 5th store refused until the first pop
    v(1, 0,0,0,    0,     0,0,    0,0,  0,         0,0,0,0,0,    0,     0,0,0,       0,0);
    v(0, 1,1,'h40, 'hD0,  0,0,    0,0,  0,         1,0,0,0,0,    0,     0,0,0,       0,0);
    v(0, 1,1,'h41, 'hD1,  0,0,    0,0,  0,         1,0,0,0,0,    0,     0,0,0,       1,1);
    v(0, 1,1,'h42, 'hD2,  0,0,    0,0,  0,         1,0,1,1,'h40, 'hD0,  0,0,0,       2,1);
    v(0, 1,1,'h43, 'hD3,  0,0,    0,0,  0,         1,0,1,1,'h40, 'hD0,  0,0,0,       3,1);
    v(0, 1,1,'h44, 'hD4,  0,0,    0,0,  0,         0,0,1,1,'h40, 'hD0,  0,0,0,       4,1);
    v(0, 1,1,'h44, 'hD4,  0,0,    0,1,  0,         0,0,1,1,'h40, 'hD0,  0,0,0,       4,1);
    v(0, 1,1,'h44, 'hD4,  0,0,    0,0,  0,         1,0,0,0,0,    0,     0,0,0,       3,1);
    v(0, 0,1,0,    0,     0,0,    0,0,  0,         0,0,1,1,'h41, 'hD1,  0,0,0,       4,1);
    // replay and pipeline load both held: REP,REP,REP,PIPE,REP
    v(1, 0,0,0,    0,     0,0,    0,0,  0,         0,0,0,0,0,    0,     0,0,0,       0,0);
    v(0, 1,0,'h20, 0,     1,'h30, 0,1,  'hBEEF,    0,1,0,0,0,    0,     0,0,0,       0,0);
    v(0, 1,0,'h20, 0,     1,'h30, 0,1,  'hBEEF,    0,0,1,0,'h30, 0,     0,0,0,       0,1);
    v(0, 1,0,'h20, 0,     1,'h30, 0,1,  'hBEEF,    0,1,0,0,0,    0,     0,1,'hBEEF,  0,0);
    v(0, 1,0,'h20, 0,     1,'h30, 0,1,  'hBEEF,    0,0,1,0,'h30, 0,     0,0,0,       0,1);
    v(0, 1,0,'h20, 0,     1,'h30, 0,1,  'hBEEF,    0,1,0,0,0,    0,     0,1,'hBEEF,  0,0);
    v(0, 1,0,'h20, 0,     1,'h30, 0,1,  'hBEEF,    0,0,1,0,'h30, 0,     0,0,0,       0,1);
    v(0, 1,0,'h20, 0,     1,'h30, 0,1,  'hBEEF,    1,0,0,0,0,    0,     0,1,'hBEEF,  0,0);
    v(0, 1,0,'h20, 0,     1,'h30, 0,1,  'hBEEF,    0,0,1,0,'h20, 0,     0,0,0,       0,1);
    v(0, 1,0,'h20, 0,     1,'h30, 0,1,  'hBEEF,    0,1,0,0,0,    0,     1,0,'hBEEF,  0,0);
    v(0, 1,0,'h20, 0,     1,'h30, 0,1,  'hBEEF,    0,0,1,0,'h30, 0,     0,0,0,       0,1);
    // flush during WAIT suppresses the pipeline response
    v(1, 0,0,0,    0,     0,0,    0,0,  0,         0,0,0,0,0,    0,     0,0,0,       0,0);
    v(0, 1,0,'h20, 0,     0,0,    0,0,  0,         1,0,0,0,0,    0,     0,0,0,       0,0);
    v(0, 0,0,0,    0,     0,0,    0,0,  0,         0,0,1,0,'h20, 0,     0,0,0,       0,1);
    v(0, 0,0,0,    0,     0,0,    1,0,  0,         0,0,1,0,'h20, 0,     0,0,0,       0,1);
    v(0, 0,0,0,    0,     0,0,    0,1,  'h55,      0,0,1,0,'h20, 0,     0,0,0,       0,1);
    v(0, 0,0,0,    0,     0,0,    0,0,  0,         0,0,0,0,0,    0,     0,0,0,       0,0);
    v(0, 0,0,0,    0,     0,0,    0,0,  0,         0,0,0,0,0,    0,     0,0,0,       0,0);
    // two buffered stores, one draining, then reset mid-WAIT
    v(1, 0,0,0,    0,     0,0,    0,0,  0,         0,0,0,0,0,    0,     0,0,0,       0,0);
    v(0, 1,1,'h50, 'hE0,  0,0,    0,0,  0,         1,0,0,0,0,    0,     0,0,0,       0,0);
    v(0, 1,1,'h51, 'hE1,  0,0,    0,0,  0,         1,0,0,0,0,    0,     0,0,0,       1,1);
    v(0, 0,1,0,    0,     0,0,    0,0,  0,         1,0,1,1,'h50, 'hE0,  0,0,0,       2,1);
    v(1, 0,0,0,    0,     0,0,    0,0,  0,         0,0,0,0,0,    0,     0,0,0,       0,0);
    v(0, 0,0,0,    0,     0,0,    0,0,  0,         0,0,0,0,0,    0,     0,0,0,       0,0);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst = tv[i].rst;
      pipe_req_valid = tv[i].pv; pipe_req_write = tv[i].pw;
      pipe_req_addr = tv[i].pa;  pipe_req_data = tv[i].pd;
      rep_req_valid = tv[i].rv;  rep_req_addr = tv[i].ra;
      flush = tv[i].fl; dc_rsp_valid = tv[i].rsv; dc_rsp_data = tv[i].rsd;
      #1;
      chk("pipe_req_ready", i, 32'(pipe_req_ready), 32'(tv[i].e_pr));
      chk("rep_req_ready",  i, 32'(rep_req_ready),  32'(tv[i].e_rr));
      chk("dc_req_valid",   i, 32'(dc_req_valid),   32'(tv[i].e_dv));
      chk("pipe_rsp_valid", i, 32'(pipe_rsp_valid), 32'(tv[i].e_prv));
      chk("rep_rsp_valid",  i, 32'(rep_rsp_valid),  32'(tv[i].e_rrv));
      chk("sb_count",       i, 32'(sb_count),       32'(tv[i].e_cnt));
      chk("busy",           i, 32'(busy),           32'(tv[i].e_busy));
      if (tv[i].e_dv) begin
        chk("dc_req_write", i, 32'(dc_req_write), 32'(tv[i].e_dw));
        chk("dc_req_addr",  i, 32'(dc_req_addr),  32'(tv[i].e_da));
        if (tv[i].e_dw) chk("dc_req_data", i, dc_req_data, tv[i].e_dd);
      end
      if (tv[i].e_prv) chk("pipe_rsp_data", i, pipe_rsp_data, tv[i].e_rd);
      if (tv[i].e_rrv) chk("rep_rsp_data",  i, rep_rsp_data,  tv[i].e_rd);
    end

    // Replay 0x30, cache answers 0x1234 on the 5th WAIT cycle; address must hold throughout.
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    rep_req_valid = 1'b1;
    rep_req_addr  = 26'h30;
    #1;
    chk("replay_grant", 1000, 32'(rep_req_ready), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      rep_req_valid = 1'b0;
      dc_rsp_valid  = (k == 5);
      dc_rsp_data   = 32'h1234;
      #1;
      chk("replay_wait_valid", 1000 + k, 32'(dc_req_valid), 32'd1);
      chk("replay_wait_addr",  1000 + k, 32'(dc_req_addr),  32'h30);
    end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      dc_rsp_valid = 1'b0;
      #1;
      if (rep_rsp_valid) begin
        pulses++;
        chk("replay_rsp_data", 1010 + k, rep_rsp_data, 32'h1234);
        chk("replay_rsp_first_cycle", 1010 + k, 32'(k), 32'd0);
      end
    end
    chk("replay_rsp_pulses", 1020, 32'(pulses), 32'd1);
    chk("replay_idle_after", 1021, 32'(busy), 32'd0);

    // Asynchronous reset asserted between clock edges while a drain is in flight.
    @(negedge clk);
    pipe_req_valid = 1'b1; pipe_req_write = 1'b1; pipe_req_addr = 26'h60; pipe_req_data = 32'hF0;
    @(negedge clk);
    pipe_req_addr = 26'h61; pipe_req_data = 32'hF1;
    @(negedge clk);
    pipe_req_valid = 1'b0;
    #1;
    chk("pre_reset_dc_valid", 1030, 32'(dc_req_valid), 32'd1);
    chk("pre_reset_sb_count", 1031, 32'(sb_count), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset_dc_valid", 1032, 32'(dc_req_valid), 32'd0);
    chk("async_reset_sb_count", 1033, 32'(sb_count), 32'd0);
    chk("async_reset_busy",     1034, 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_busy", 1035, 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
